// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Phase counter, program counter and OPR/OPA/second-word latches
//             sitting between the instruction ROM and the decoder.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int NIB_W  = 4,
  parameter int PHASES = 8,
  parameter int M1_IDX = 3,
  parameter int M2_IDX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIB_W-1:0]          romNibble,
  input  logic                      twoWordReq,
  input  logic                      pcLoad,
  input  logic [ADDR_W-1:0]         pcNew,
  input  logic                      hold,
  output logic [$clog2(PHASES)-1:0] cycle,
  output logic                      sync,
  output logic [ADDR_W-1:0]         pcAddr,
  output logic [NIB_W-1:0]          opr,
  output logic [NIB_W-1:0]          opa,
  output logic [2*NIB_W-1:0]        word2,
  output logic                      secondWord,
  output logic                      instrDone
);

  localparam int              CYC_W  = $clog2(PHASES);
  localparam logic [CYC_W-1:0] c_LAST = CYC_W'(PHASES - 1);
  localparam logic [CYC_W-1:0] c_M1   = CYC_W'(M1_IDX);
  localparam logic [CYC_W-1:0] c_M2   = CYC_W'(M2_IDX);

  logic [CYC_W-1:0]   r_cycle;
  logic [ADDR_W-1:0]  r_pcAddr;
  logic [NIB_W-1:0]   r_opr;
  logic [NIB_W-1:0]   r_opa;
  logic [2*NIB_W-1:0] r_word2;
  logic               r_secondWord;
  logic               r_instrDone;

  logic [CYC_W-1:0]   w_cycleNext;
  logic [ADDR_W-1:0]  w_pcAddrNext;
  logic [NIB_W-1:0]   w_oprNext;
  logic [NIB_W-1:0]   w_opaNext;
  logic [2*NIB_W-1:0] w_word2Next;
  logic               w_secondWordNext;
  logic               w_instrDoneNext;
  logic               w_isLast;
  logic               w_stall;

  assign w_isLast = (r_cycle == c_LAST);
  // A stall is only honoured on the last phase; the whole sequencer freezes.
  assign w_stall  = w_isLast && hold;

  always_comb begin
    w_cycleNext      = r_cycle;
    w_pcAddrNext     = r_pcAddr;
    w_oprNext        = r_opr;
    w_opaNext        = r_opa;
    w_word2Next      = r_word2;
    w_secondWordNext = r_secondWord;
    w_instrDoneNext  = r_instrDone;

    if (!w_stall) begin
      w_cycleNext     = w_isLast ? '0 : r_cycle + CYC_W'(1);
      w_instrDoneNext = 1'b0;

      if (r_cycle == c_M1) begin
        if (r_secondWord) w_word2Next[2*NIB_W-1:NIB_W] = romNibble;
        else              w_oprNext = romNibble;
      end

      if (r_cycle == c_M2) begin
        if (r_secondWord) w_word2Next[NIB_W-1:0] = romNibble;
        else              w_opaNext = romNibble;
        w_pcAddrNext = r_pcAddr + ADDR_W'(1);
      end

      // Jump target overrides the increment even when M2 is the last phase.
      if (w_isLast) begin
        if (pcLoad) begin
          w_pcAddrNext     = pcNew;
          w_secondWordNext = 1'b0;
          w_instrDoneNext  = 1'b1;
        end else if (!r_secondWord && twoWordReq) begin
          w_secondWordNext = 1'b1;
        end else begin
          w_secondWordNext = 1'b0;
          w_instrDoneNext  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle      <= '0;
      r_pcAddr     <= '0;
      r_opr        <= '0;
      r_opa        <= '0;
      r_word2      <= '0;
      r_secondWord <= 1'b0;
      r_instrDone  <= 1'b0;
    end else begin
      r_cycle      <= w_cycleNext;
      r_pcAddr     <= w_pcAddrNext;
      r_opr        <= w_oprNext;
      r_opa        <= w_opaNext;
      r_word2      <= w_word2Next;
      r_secondWord <= w_secondWordNext;
      r_instrDone  <= w_instrDoneNext;
    end
  end

  assign cycle      = r_cycle;
  assign sync       = rst || (r_cycle == '0);
  assign pcAddr     = r_pcAddr;
  assign opr        = r_opr;
  assign opa        = r_opa;
  assign word2      = r_word2;
  assign secondWord = r_secondWord;
  assign instrDone  = r_instrDone;

endmodule
`default_nettype wire
